// File: rtl/z80_io_pkg.sv
// Shared constants for the wb_z80 I/O-space peripherals.
// Holds Wishbone cycle-tag encodings, timer register offsets, CTRL bit
// positions and the CTRL register layout.
package z80_io_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADR_W  = 16;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned OFS_W  = 3;

  // Wishbone cycle tags driven by the core
  localparam logic [1:0] TGA_MEM  = 2'b00;
  localparam logic [1:0] TGA_IO   = 2'b01;
  localparam logic [1:0] TGA_INTA = 2'b10;

  // Timer register offsets within the 8-port window
  localparam logic [OFS_W-1:0] OFS_CTRL     = 3'd0;
  localparam logic [OFS_W-1:0] OFS_PRESC    = 3'd1;
  localparam logic [OFS_W-1:0] OFS_RELOAD_L = 3'd2;
  localparam logic [OFS_W-1:0] OFS_RELOAD_H = 3'd3;
  localparam logic [OFS_W-1:0] OFS_COUNT_L  = 3'd4;
  localparam logic [OFS_W-1:0] OFS_COUNT_H  = 3'd5;
  localparam logic [OFS_W-1:0] OFS_STATUS   = 3'd6;
  localparam logic [OFS_W-1:0] OFS_VECTOR   = 3'd7;

  // CTRL bit indices
  localparam int unsigned CTRL_EN_BIT   = 0;
  localparam int unsigned CTRL_AUTO_BIT = 1;
  localparam int unsigned CTRL_IE_BIT   = 2;

  // CTRL storage; bit 0 is EN, matching the bit indices above
  typedef struct packed {
    logic ie;
    logic auto_rl;
    logic en;
  } ctrl_t;

endpackage

// File: rtl/z80_timer_core.sv
// Prescaler plus 16-bit down counter for z80_io_timer.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   en, auto_rl    : CTRL.EN / CTRL.AUTO
//   presc          : prescaler compare value (tick every presc+1 clocks)
//   reload         : value loaded on load strobe or on auto-reload
//   load           : RELOAD_H write strobe, loads count from reload
//   presc_wr       : PRESC write strobe, zeroes the prescaler
//   count          : current counter value (registered)
//   zero_tick_c    : tick taken while count==0 (sets TF)
//   en_clr_c       : zero tick in one-shot mode (clears EN)
module z80_timer_core
  import z80_io_pkg::*;
#(
  parameter int unsigned PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               auto_rl,
  input  logic [PRESC_W-1:0] presc,
  input  logic [CNT_W-1:0]   reload,
  input  logic               load,
  input  logic               presc_wr,
  output logic [CNT_W-1:0]   count,
  output logic               zero_tick_c,
  output logic               en_clr_c
);

  logic [PRESC_W-1:0] presc_cnt;
  logic               tick_c;

  assign tick_c      = en && (presc_cnt == presc);
  assign zero_tick_c = tick_c && (count == '0);
  assign en_clr_c    = zero_tick_c && !auto_rl;

  // Prescaler and counter; a RELOAD_H load overrides any tick action
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_cnt <= '0;
      count     <= '0;
    end else begin
      if (!en || presc_wr || tick_c) begin
        presc_cnt <= '0;
      end else begin
        presc_cnt <= presc_cnt + PRESC_W'(1);
      end

      if (load) begin
        count <= reload;
      end else if (tick_c) begin
        if (count != '0) begin
          count <= count - CNT_W'(1);
        end else if (auto_rl) begin
          count <= reload;
        end
      end
    end
  end

endmodule

// File: rtl/z80_io_timer.sv
// Wishbone I/O-space timer for the wb_z80 core: 16-bit down counter with
// prescaler, TF flag and maskable interrupt request.
// Optional feature: define Z80_TIMER_IM2_VECTOR_EN to add the VECTOR
// register (offset 7) and answer interrupt-acknowledge cycles with it.
// Ports:
//   wb_clk_i, wb_rst_i : clock, synchronous active-high reset
//   wb_adr_i           : address, [7:3] matched against BASE_ADR, [2:0] offset
//   wb_dat_i/wb_dat_o  : write/read data; wb_dat_o is 0 when not acking a read
//   wb_we_i, wb_cyc_i, wb_stb_i, wb_tga_i : Wishbone cycle controls and tag
//   wb_ack_o           : one-cycle acknowledge
//   int_req_o          : registered TF & IE
module z80_io_timer
  import z80_io_pkg::*;
#(
  parameter logic [7:0]  BASE_ADR = 8'h40,
  parameter int unsigned PRESC_W  = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [ADR_W-1:0]  wb_adr_i,
  input  logic [DATA_W-1:0] wb_dat_i,
  output logic [DATA_W-1:0] wb_dat_o,
  input  logic              wb_we_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic [1:0]        wb_tga_i,
  output logic              wb_ack_o,
  output logic              int_req_o
);

  ctrl_t              ctrl;
  logic [PRESC_W-1:0] presc;
  logic [DATA_W-1:0]  reload_l;
  logic [DATA_W-1:0]  reload_h;
  logic [DATA_W-1:0]  shadow;
  logic               tf;
  logic [CNT_W-1:0]   count;
  logic               zero_tick_c;
  logic               en_clr_c;

  logic               io_sel_c;
  logic               req_c;
  logic               wr_c;
  logic               rd_c;
  logic               inta_c;
  logic [OFS_W-1:0]   ofs_c;
  logic               load_c;
  logic               presc_wr_c;
  logic [CNT_W-1:0]   reload_c;
  logic [DATA_W-1:0]  rdata_c;
  logic               unused_adr_hi;

`ifdef Z80_TIMER_IM2_VECTOR_EN
  logic [DATA_W-1:0]  vector;
`endif

  // Only the low address byte is decoded in I/O space
  assign unused_adr_hi = ^wb_adr_i[ADR_W-1:8];

  assign io_sel_c = (wb_tga_i == TGA_IO) && (wb_adr_i[7:3] == BASE_ADR[7:3]);
  assign req_c    = wb_cyc_i && wb_stb_i && io_sel_c && !wb_ack_o;
  assign wr_c     = req_c && wb_we_i;
  assign rd_c     = req_c && !wb_we_i;
  assign ofs_c    = wb_adr_i[OFS_W-1:0];

`ifdef Z80_TIMER_IM2_VECTOR_EN
  assign inta_c = wb_cyc_i && wb_stb_i && (wb_tga_i == TGA_INTA) && int_req_o && !wb_ack_o;
`else
  assign inta_c = 1'b0;
`endif

  assign load_c     = wr_c && (ofs_c == OFS_RELOAD_H);
  assign presc_wr_c = wr_c && (ofs_c == OFS_PRESC);
  // On a RELOAD_H write the counter must see the incoming high byte
  assign reload_c   = {(load_c ? wb_dat_i : reload_h), reload_l};

  z80_timer_core #(
    .PRESC_W (PRESC_W)
  ) u_core (
    .clk         (wb_clk_i),
    .rst         (wb_rst_i),
    .en          (ctrl.en),
    .auto_rl     (ctrl.auto_rl),
    .presc       (presc),
    .reload      (reload_c),
    .load        (load_c),
    .presc_wr    (presc_wr_c),
    .count       (count),
    .zero_tick_c (zero_tick_c),
    .en_clr_c    (en_clr_c)
  );

  // Register read mux
  always_comb begin
    rdata_c = '0;
    case (ofs_c)
      OFS_CTRL:     rdata_c = {5'b0, ctrl};
      OFS_PRESC:    rdata_c = DATA_W'(presc);
      OFS_RELOAD_L: rdata_c = reload_l;
      OFS_RELOAD_H: rdata_c = reload_h;
      OFS_COUNT_L:  rdata_c = count[7:0];
      OFS_COUNT_H:  rdata_c = shadow;
      OFS_STATUS:   rdata_c = {7'b0, tf};
`ifdef Z80_TIMER_IM2_VECTOR_EN
      OFS_VECTOR:   rdata_c = vector;
`endif
      default:      rdata_c = '0;
    endcase
  end

  // Bus response, register writes and flag updates
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wb_ack_o  <= 1'b0;
      wb_dat_o  <= '0;
      int_req_o <= 1'b0;
      ctrl      <= '0;
      presc     <= '0;
      reload_l  <= '0;
      reload_h  <= '0;
      shadow    <= '0;
      tf        <= 1'b0;
`ifdef Z80_TIMER_IM2_VECTOR_EN
      vector    <= '0;
`endif
    end else begin
      wb_ack_o  <= req_c || inta_c;
      int_req_o <= tf && ctrl.ie;

      wb_dat_o <= '0;
      if (rd_c) begin
        wb_dat_o <= rdata_c;
      end
`ifdef Z80_TIMER_IM2_VECTOR_EN
      if (inta_c) begin
        wb_dat_o <= vector;
      end
`endif

      // A CTRL write overrides the one-shot EN clear
      if (wr_c && (ofs_c == OFS_CTRL)) begin
        ctrl.en      <= wb_dat_i[CTRL_EN_BIT];
        ctrl.auto_rl <= wb_dat_i[CTRL_AUTO_BIT];
        ctrl.ie      <= wb_dat_i[CTRL_IE_BIT];
      end else if (en_clr_c) begin
        ctrl.en <= 1'b0;
      end

      if (presc_wr_c) begin
        presc <= PRESC_W'(wb_dat_i);
      end
      if (wr_c && (ofs_c == OFS_RELOAD_L)) begin
        reload_l <= wb_dat_i;
      end
      if (load_c) begin
        reload_h <= wb_dat_i;
      end
`ifdef Z80_TIMER_IM2_VECTOR_EN
      if (wr_c && (ofs_c == OFS_VECTOR)) begin
        vector <= wb_dat_i;
      end
`endif

      // Reading COUNT_L freezes the high byte for a coherent 16-bit read
      if (rd_c && (ofs_c == OFS_COUNT_L)) begin
        shadow <= count[15:8];
      end

      // A setting tick beats a software clear
      if (zero_tick_c) begin
        tf <= 1'b1;
      end else if (wr_c && (ofs_c == OFS_STATUS) && wb_dat_i[0]) begin
        tf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_z80_io_timer.sv
// Directed self-checking bench for z80_io_timer.
`timescale 1ns/1ps
module tb_z80_io_timer;
  import z80_io_pkg::*;

  localparam logic [7:0] BASE = 8'h40;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] wb_adr_i;
  logic [7:0]  wb_dat_i;
  logic [7:0]  wb_dat_o;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic [1:0]  wb_tga_i;
  logic        wb_ack_o;
  logic        int_req_o;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;

  z80_io_timer dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wb_adr_i  (wb_adr_i),
    .wb_dat_i  (wb_dat_i),
    .wb_dat_o  (wb_dat_o),
    .wb_we_i   (wb_we_i),
    .wb_cyc_i  (wb_cyc_i),
    .wb_stb_i  (wb_stb_i),
    .wb_tga_i  (wb_tga_i),
    .wb_ack_o  (wb_ack_o),
    .int_req_o (int_req_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // One single-cycle strobe; outputs sampled at the following negedge
  task automatic bus(input logic we, input logic [1:0] tga, input logic [7:0] adr,
                     input logic [7:0] wd, output logic [7:0] rd, output logic acked);
    @(negedge clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_tga_i = tga;
    wb_adr_i = {8'h00, adr}; wb_dat_i = wd;
    @(negedge clk);
    acked = wb_ack_o; rd = wb_dat_o;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_dat_i = 8'h00;
  endtask

  task automatic io_wr(input logic [2:0] ofs, input logic [7:0] wd);
    logic [7:0] d;
    logic a;
    bus(1'b1, TGA_IO, BASE | {5'b0, ofs}, wd, d, a);
  endtask

  task automatic io_rd(input logic [2:0] ofs, output logic [7:0] d, output logic a);
    bus(1'b0, TGA_IO, BASE | {5'b0, ofs}, 8'h00, d, a);
  endtask

  // Returns the index of the posedge after which int_req_o first reads 1, or -1
  task automatic wait_int(input int limit, output int at);
    at = -1;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (int_req_o === 1'b1) begin
        at = cyc_cnt;
        break;
      end
    end
  endtask

  task automatic test_reset;
    logic [7:0] d;
    logic a;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (wb_ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b exp 0", wb_ack_o); end
    checks++; if (wb_dat_o !== 8'h00) begin errors++; $display("FAIL reset_dat: got %h exp 00", wb_dat_o); end
    checks++; if (int_req_o !== 1'b0) begin errors++; $display("FAIL reset_int: got %b exp 0", int_req_o); end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      io_rd(3'(i), d, a);
      checks++; if (a !== 1'b1) begin errors++; $display("FAIL reset_rd_ack ofs %0d: got %b exp 1", i, a); end
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_rd_dat ofs %0d: got %h exp 00", i, d); end
    end
    @(negedge clk);
    checks++; if (wb_ack_o !== 1'b0) begin errors++; $display("FAIL ack_single: got %b exp 0", wb_ack_o); end
    checks++; if (int_req_o !== 1'b0) begin errors++; $display("FAIL reset_int_idle: got %b exp 0", int_req_o); end
  endtask

  task automatic test_periodic;
    int t0;
    int at;
    io_wr(OFS_PRESC, 8'h03);
    io_wr(OFS_RELOAD_L, 8'h02);
    io_wr(OFS_RELOAD_H, 8'h00);
    io_wr(OFS_CTRL, 8'h07);
    t0 = cyc_cnt;
    wait_int(40, at);
    checks++; if (at !== t0 + 13) begin errors++; $display("FAIL periodic_rise1: got %0d exp %0d", at - t0, 13); end
    io_wr(OFS_STATUS, 8'h01);
    checks++; if (int_req_o !== 1'b1) begin errors++; $display("FAIL periodic_hold: got %b exp 1", int_req_o); end
    @(negedge clk);
    checks++; if (int_req_o !== 1'b0) begin errors++; $display("FAIL periodic_fall: got %b exp 0", int_req_o); end
    wait_int(40, at);
    checks++; if (at !== t0 + 25) begin errors++; $display("FAIL periodic_rise2: got %0d exp %0d", at - t0, 25); end
    io_wr(OFS_CTRL, 8'h00);
    io_wr(OFS_STATUS, 8'h01);
  endtask

  task automatic test_one_shot;
    int t0;
    int at;
    logic [7:0] d;
    logic a;
    io_wr(OFS_PRESC, 8'h00);
    io_wr(OFS_RELOAD_L, 8'h01);
    io_wr(OFS_RELOAD_H, 8'h00);
    io_wr(OFS_CTRL, 8'h05);
    t0 = cyc_cnt;
    wait_int(20, at);
    checks++; if (at !== t0 + 3) begin errors++; $display("FAIL oneshot_rise: got %0d exp %0d", at - t0, 3); end
    io_rd(OFS_CTRL, d, a);
    checks++; if (d !== 8'h04) begin errors++; $display("FAIL oneshot_ctrl: got %h exp 04", d); end
    io_rd(OFS_STATUS, d, a);
    checks++; if (d !== 8'h01) begin errors++; $display("FAIL oneshot_tf: got %h exp 01", d); end
    io_rd(OFS_COUNT_L, d, a);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL oneshot_cnt_l: got %h exp 00", d); end
    io_rd(OFS_COUNT_H, d, a);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL oneshot_cnt_h: got %h exp 00", d); end
  endtask

  task automatic test_set_vs_clear;
    logic [7:0] d;
    logic a;
    io_wr(OFS_STATUS, 8'h01);
    io_wr(OFS_RELOAD_H, 8'h00);
    io_wr(OFS_CTRL, 8'h05);
    io_wr(OFS_STATUS, 8'h01);   // lands on the TF-setting tick edge
    io_rd(OFS_STATUS, d, a);
    checks++; if (d !== 8'h01) begin errors++; $display("FAIL set_wins: got %h exp 01", d); end
    checks++; if (int_req_o !== 1'b1) begin errors++; $display("FAIL set_wins_int: got %b exp 1", int_req_o); end
    io_wr(OFS_STATUS, 8'h01);
    checks++; if (int_req_o !== 1'b1) begin errors++; $display("FAIL clr_int_hold: got %b exp 1", int_req_o); end
    @(negedge clk);
    checks++; if (int_req_o !== 1'b0) begin errors++; $display("FAIL clr_int_fall: got %b exp 0", int_req_o); end
    io_rd(OFS_STATUS, d, a);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL clr_tf: got %h exp 00", d); end
  endtask

  task automatic test_count_shadow;
    logic [7:0] d;
    logic a;
    io_wr(OFS_CTRL, 8'h00);
    io_wr(OFS_PRESC, 8'h00);
    io_wr(OFS_RELOAD_L, 8'hFF);
    io_wr(OFS_RELOAD_H, 8'h12);
    io_rd(OFS_COUNT_L, d, a);
    checks++; if (d !== 8'hFF) begin errors++; $display("FAIL shadow_cnt_l: got %h exp FF", d); end
    io_wr(OFS_CTRL, 8'h01);
    repeat (300) @(negedge clk);
    io_wr(OFS_CTRL, 8'h00);
    io_rd(OFS_COUNT_H, d, a);
    checks++; if (d !== 8'h12) begin errors++; $display("FAIL shadow_cnt_h: got %h exp 12", d); end
    io_rd(OFS_RELOAD_L, d, a);
    checks++; if (d !== 8'hFF) begin errors++; $display("FAIL reload_l_rb: got %h exp FF", d); end
    io_rd(OFS_RELOAD_H, d, a);
    checks++; if (d !== 8'h12) begin errors++; $display("FAIL reload_h_rb: got %h exp 12", d); end
    io_wr(OFS_PRESC, 8'hA5);
    io_rd(OFS_PRESC, d, a);
    checks++; if (d !== 8'hA5) begin errors++; $display("FAIL presc_rb: got %h exp A5", d); end
    io_wr(OFS_COUNT_H, 8'h77);
    io_rd(OFS_COUNT_H, d, a);
    checks++; if (d !== 8'h12) begin errors++; $display("FAIL ro_write: got %h exp 12", d); end
  endtask

  task automatic test_back_to_back;
    logic exp_ack;
    @(negedge clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_tga_i = TGA_IO;
    wb_adr_i = {8'h00, BASE | {5'b0, OFS_RELOAD_L}};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      exp_ack = (k % 2 == 0);
      checks++; if (wb_ack_o !== exp_ack) begin errors++; $display("FAIL b2b_ack cyc %0d: got %b exp %b", k, wb_ack_o, exp_ack); end
      checks++; if (wb_dat_o !== (exp_ack ? 8'hFF : 8'h00)) begin errors++; $display("FAIL b2b_dat cyc %0d: got %h", k, wb_dat_o); end
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
  endtask

  task automatic test_decode_inta;
    int acks;
    logic [7:0] d;
    logic a;
    // wrong base, then memory tag at the right base
    for (int p = 0; p < 2; p++) begin
      @(negedge clk);
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
      wb_tga_i = (p == 0) ? TGA_IO : TGA_MEM;
      wb_adr_i = (p == 0) ? 16'h0048 : 16'h0040;
      acks = 0;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (wb_ack_o === 1'b1) acks++;
      end
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      checks++; if (acks !== 0) begin errors++; $display("FAIL decode_noack case %0d: got %0d acks exp 0", p, acks); end
    end
    io_wr(OFS_VECTOR, 8'hE4);
    io_wr(OFS_RELOAD_L, 8'h00);
    io_wr(OFS_RELOAD_H, 8'h00);
    io_wr(OFS_PRESC, 8'h00);
    io_wr(OFS_CTRL, 8'h05);
    repeat (3) @(negedge clk);
    checks++; if (int_req_o !== 1'b1) begin errors++; $display("FAIL inta_setup: got %b exp 1", int_req_o); end
    @(negedge clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_tga_i = TGA_INTA; wb_adr_i = 16'h00FF;
`ifdef Z80_TIMER_IM2_VECTOR_EN
    @(negedge clk);
    checks++; if (wb_ack_o !== 1'b1) begin errors++; $display("FAIL inta_ack: got %b exp 1", wb_ack_o); end
    checks++; if (wb_dat_o !== 8'hE4) begin errors++; $display("FAIL inta_vec: got %h exp E4", wb_dat_o); end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    io_rd(OFS_VECTOR, d, a);
    checks++; if (d !== 8'hE4) begin errors++; $display("FAIL vector_rb: got %h exp E4", d); end
`else
    acks = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (wb_ack_o === 1'b1) acks++;
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    checks++; if (acks !== 0) begin errors++; $display("FAIL inta_noack: got %0d acks exp 0", acks); end
    io_rd(OFS_VECTOR, d, a);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL vector_absent: got %h exp 00", d); end
`endif
    io_rd(OFS_STATUS, d, a);
    checks++; if (d !== 8'h01) begin errors++; $display("FAIL inta_tf_kept: got %h exp 01", d); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] d;
    logic a;
    @(negedge clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_tga_i = TGA_IO;
    wb_adr_i = {8'h00, BASE | {5'b0, OFS_CTRL}};
    rst = 1'b1;
    @(negedge clk);
    checks++; if (wb_ack_o !== 1'b0) begin errors++; $display("FAIL midrst_ack: got %b exp 0", wb_ack_o); end
    checks++; if (wb_dat_o !== 8'h00) begin errors++; $display("FAIL midrst_dat: got %h exp 00", wb_dat_o); end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    rst = 1'b0;
    io_rd(OFS_CTRL, d, a);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL midrst_ctrl: got %h exp 00", d); end
    io_rd(OFS_STATUS, d, a);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL midrst_tf: got %h exp 00", d); end
    checks++; if (int_req_o !== 1'b0) begin errors++; $display("FAIL midrst_int: got %b exp 0", int_req_o); end
  endtask

  initial begin
    rst = 1'b1;
    wb_adr_i = 16'h0000; wb_dat_i = 8'h00; wb_we_i = 1'b0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_tga_i = TGA_MEM;
    test_reset();
    test_periodic();
    test_one_shot();
    test_set_vs_clear();
    test_count_shadow();
    test_back_to_back();
    test_decode_inta();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
